// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST checker.
// Holds the FSM state type, truth-table constants for common gates and the settle-timer width.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit i of each table is the expected gate output for pattern i = {a,b}
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam int unsigned TIMER_W = 8;

    function automatic logic [TIMER_W-1:0] settle_load(input int unsigned settle);
        return TIMER_W'(settle - 1);
    endfunction

endpackage

// File: rtl/gate_bist_checker_timer.sv
// bist_settle_timer: 8-bit loadable down-counter with a zero flag.
// It holds at zero rather than wrapping.
module bist_settle_timer
    import gate_bist_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: drives patterns 00..11 into a 2-input gate and checks its response against TRUTH.
// Optional fail_map output is enabled by defining GATE_BIST_FAILMAP_EN.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = TT_XOR,
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_result,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
`ifdef GATE_BIST_FAILMAP_EN
    ,
    output logic [3:0] fail_map
`endif
);

    state_t     state;
    logic [1:0] idx;
    logic       accept;
    logic       mismatch;
    logic [2:0] err_next;
    logic       timer_load;
    logic       timer_en;
    logic       timer_zero;

    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch   = (dut_result != TRUTH[idx]);
    assign err_next   = err_count + {2'b00, mismatch};
    // Reload on run entry and on every SAMPLE that continues to another pattern
    assign timer_load = accept || ((state == ST_SAMPLE) && (idx != 2'd3));
    assign timer_en   = (state == ST_APPLY);

    bist_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (settle_load(SETTLE)),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef GATE_BIST_FAILMAP_EN
            fail_map  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        idx       <= '0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
`ifdef GATE_BIST_FAILMAP_EN
                        fail_map  <= '0;
`endif
                    end
                end
                ST_APPLY: begin
                    if (timer_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
`ifdef GATE_BIST_FAILMAP_EN
                    fail_map[idx] <= mismatch;
`endif
                    if (idx == 2'd3) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                    end else begin
                        state          <= ST_APPLY;
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: XOR/SETTLE=4 and AND/SETTLE=1 instances with modelled gates.
// Fail-map checks are compiled in when GATE_BIST_FAILMAP_EN is defined.
module tb_gate_bist_checker;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   sel;
    int   mode1;
    int   mode2;

    always #5 clk = ~clk;

    logic       start1, res1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic       start2, res2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fm1, fm2;

    assign start1 = start && (sel == 0);
    assign start2 = start && (sel == 1);

    // mode1: 0 good XOR, 1 stuck-at-0, 2 XNOR; mode2: 0 good AND, 1 stuck-at-1
    always_comb begin
        case (mode1)
            0:       res1 = a1 ^ b1;
            1:       res1 = 1'b0;
            default: res1 = ~(a1 ^ b1);
        endcase
    end

    always_comb res2 = (mode2 == 0) ? (a2 & b2) : 1'b1;

    gate_bist_checker #(.TRUTH(TT_XOR), .SETTLE(4)) u_dut_xor (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .dut_result (res1),
        .a_out      (a1),
        .b_out      (b1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err1)
`ifdef GATE_BIST_FAILMAP_EN
        ,
        .fail_map   (fm1)
`endif
    );

    gate_bist_checker #(.TRUTH(TT_AND), .SETTLE(1)) u_dut_and (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .dut_result (res2),
        .a_out      (a2),
        .b_out      (b2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_count  (err2)
`ifdef GATE_BIST_FAILMAP_EN
        ,
        .fail_map   (fm2)
`endif
    );

`ifndef GATE_BIST_FAILMAP_EN
    assign fm1 = '0;
    assign fm2 = '0;
`endif

    logic       oa, ob, obusy, odone, opass;
    logic [2:0] oerr;
    logic [3:0] ofm;

    always_comb begin
        if (sel == 0) begin
            {oa, ob, obusy, odone, opass, oerr, ofm} = {a1, b1, busy1, done1, pass1, err1, fm1};
        end else begin
            {oa, ob, obusy, odone, opass, oerr, ofm} = {a2, b2, busy2, done2, pass2, err2, fm2};
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full run from IDLE/DONE; start is re-raised after check j==mid (mid<0: never)
    task automatic run(input int unsigned s, input int mid, input logic [2:0] exp_err,
                       input logic exp_pass, input logic [3:0] exp_map);
        int unsigned total;
        int unsigned p;
        logic [1:0]  pb;
        total = 4 * (s + 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clear_err", 32'(oerr), 32'd0);
        check("clear_pass", 32'(opass), 32'd0);
        for (int j = 0; j < int'(total); j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            p  = int'(j) / (s + 1);
            pb = p[1:0];
            check("seq", 32'({oa, ob, obusy, odone}), 32'({pb, 1'b1, 1'b0}));
            if (j == mid) start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_outs", 32'({oa, ob, obusy, odone}), 32'(4'b0001));
        check("pass", 32'(opass), 32'(exp_pass));
        check("err_count", 32'(oerr), 32'(exp_err));
`ifdef GATE_BIST_FAILMAP_EN
        check("fail_map", 32'(ofm), 32'(exp_map));
`else
        if (exp_map !== exp_map) check("fail_map", 32'(ofm), 32'(exp_map));
`endif
        @(posedge clk);
        #1;
        check("done_hold", 32'({odone, opass, oerr}), 32'({1'b1, exp_pass, exp_err}));
    endtask

    typedef struct {
        int         sel;
        int         mode;
        int         settle;
        int         mid;
        logic [2:0] err;
        logic       pass;
        logic [3:0] map;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 0, 4, -1, 3'd0, 1'b1, 4'b0000};
        tbl[1] = '{0, 1, 4, -1, 3'd2, 1'b0, 4'b0110};
        tbl[2] = '{0, 2, 4, -1, 3'd4, 1'b0, 4'b1111};
        tbl[3] = '{0, 0, 4,  4, 3'd0, 1'b1, 4'b0000};
        tbl[4] = '{0, 1, 4, 18, 3'd2, 1'b0, 4'b0110};
        tbl[5] = '{1, 1, 1, -1, 3'd3, 1'b0, 4'b0111};
        tbl[6] = '{1, 0, 1, -1, 3'd0, 1'b1, 4'b0000};

        rst   = 1'b1;
        start = 1'b0;
        sel   = 0;
        mode1 = 0;
        mode2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_xor", 32'({a1, b1, busy1, done1, pass1, err1}), 32'd0);
        check("rst_and", 32'({a2, b2, busy2, done2, pass2, err2}), 32'd0);
`ifdef GATE_BIST_FAILMAP_EN
        check("rst_map", 32'({fm1, fm2}), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            sel = tbl[i].sel;
            if (tbl[i].sel == 0) mode1 = tbl[i].mode;
            else                 mode2 = tbl[i].mode;
            run(tbl[i].settle, tbl[i].mid, tbl[i].err, tbl[i].pass, tbl[i].map);
        end

        // Async reset while pattern 10 is in SAMPLE, then a clean rerun
        sel   = 0;
        mode1 = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_rst", 32'({oa, ob, obusy, oerr}), 32'({2'b10, 1'b1, 3'd1}));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({oa, ob, obusy, odone, opass, oerr}), 32'd0);
`ifdef GATE_BIST_FAILMAP_EN
        check("async_rst_map", 32'(ofm), 32'd0);
`endif
        @(negedge clk);
        rst   = 1'b0;
        mode1 = 0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'({obusy, odone}), 32'd0);
        run(4, -1, 3'd0, 1'b1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
